spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//   Receive-side SPI target for the spi_master link: deserialises MSB-first WORD_W-bit words from mosi
//   while cs_n is low, and buffers completed words in a DEPTH-entry FIFO drained by a valid/ready port.
//   Sits on the far end of the SPI link. sclk/mosi/cs_n are synchronous to clk, so there are no synchronisers.
//   Supports back-to-back words in one cs_n frame (master holding cs_n) and flags truncated frames.
// PARAMETERS
//   WORD_W   32   bits per received word
//   DEPTH    4    FIFO entries; power of two, >= 2
// PORTS
//   clk           in   1                  system clock; all logic on posedge
//   rst           in   1                  asynchronous reset, active-high
//   sclk          in   1                  SPI clock from master; idles low
//   mosi          in   1                  SPI data; master updates it as sclk rises
//   cs_n          in   1                  chip select, active-low
//   rx_data       out  WORD_W             FIFO head word (valid only when rx_valid=1)
//   rx_valid      out  1                  FIFO non-empty
//   rx_ready      in   1                  consumer accepts head when rx_valid & rx_ready
//   rx_level      out  $clog2(DEPTH)+1    number of words held in the FIFO
//   active        out  1                  registered cs_n, inverted (=~cs_q)
//   frame_err     out  1                  one-cycle pulse: cs_n rose with a partial word
//   overflow      out  1                  sticky: a completed word was dropped because the FIFO was full
//   clr_overflow  in   1                  synchronous clear of overflow
// BEHAVIOUR
//   Reset (async, rst=1): sclk_q=0, cs_q=1, bit_cnt=0, shift=0, FIFO empty (wr_ptr=rd_ptr=0).
//     Resulting outputs: rx_valid=0, rx_level=0, rx_data=0, active=0, frame_err=0, overflow=0.
//     Reset mid-word discards the partial word and all buffered words.
//   Edge detect: sclk_q and cs_q are the values of sclk and cs_n registered each clk.
//     A sample occurs when (sclk_q==1 && sclk==0 && cs_q==0).
//     cs_q is used instead of cs_n because the master raises cs_n on the same edge that makes the
//     last sclk fall, and that final bit must still be captured.
//   On a sample: shift <= {shift[WORD_W-2:0], mosi}.
//     If bit_cnt==WORD_W-1: push {shift[WORD_W-2:0],mosi} into the FIFO and set bit_cnt<=0.
//     Otherwise bit_cnt<=bit_cnt+1.
//   State (derived from cs_q): IDLE (cs_q=1) -> RECV on a cs_n fall (cs_q=1, cs_n=0).
//     The cs_n fall forces bit_cnt<=0. RECV -> IDLE on a cs_n rise (cs_q=0, cs_n=1).
//   cs_n rise: if bit_cnt after any same-cycle sample is nonzero, pulse frame_err for 1 cycle,
//     set bit_cnt<=0 and discard the partial word. A sample completing a word in the same cycle is
//     pushed and raises no error.
//   Multiple words per frame: bit_cnt wraps to 0 after each word, and reception continues while cs_n stays low.
//   Gaps where sclk idles low inside a frame are legal and change nothing.
//   Rising sclk edges are ignored. sclk activity while cs_q=1 is ignored.
//   FIFO: push latency is 1 clk. A word pushed at edge N gives rx_valid=1 and rx_data=word after edge N.
//     rx_data is the head entry. A pop (rx_valid & rx_ready) advances the head on that edge.
//     rx_ready with rx_valid=0 has no effect.
//   Full FIFO + push without pop: the word is dropped, overflow<=1, and FIFO contents are unchanged.
//   Full FIFO + push + pop in the same cycle: both happen, the level stays DEPTH, and there is no overflow.
//   Empty FIFO + push + pop: the pop is illegal (rx_valid=0) and ignored; the push proceeds.
//   rx_level = wr_ptr - rd_ptr. Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
//   overflow stays set until clr_overflow=1. If a set and clr_overflow happen in the same cycle, set wins.
//   Throughput: the link runs at most 1 bit per 2 clk, so the shifter never stalls.
//     FIFO back-pressure only causes drops, never stalls.
// TESTING
//   T1: master sends 0xA5A5_0F0F, hold_cs=0, rx_ready=1 -> one word 0xA5A50F0F with rx_valid high
//       for 1 cycle; frame_err=0; final bit captured despite the simultaneous cs_n rise.
//   T2: hold_cs=1, three words 0x1,0x80000000,0xDEADBEEF back-to-back, rx_ready=0 -> rx_level=3;
//       then pop in order 0x00000001, 0x80000000, 0xDEADBEEF.
//   T3: drive cs_n high after 17 sclk falls -> frame_err one-cycle pulse, no push; the next full
//       word 0x12345678 is received correctly.
//   T4: rx_ready=0, send DEPTH+1=5 words -> rx_level=4, overflow=1, head = first word, 5th word lost;
//       clr_overflow=1 -> overflow=0.
//   T5: FIFO full, rx_ready=1 in the exact cycle the next word completes -> level stays 4,
//       overflow stays 0, word order preserved.
//   T6: assert rst after 10 bits of a word with 2 words buffered -> all outputs return to reset values
//       immediately; a subsequent 0xCAFEF00D is received intact.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI receive target: deserialises MSB-first words on falling sclk while selected,
// and buffers completed words in a DEPTH-entry FIFO drained through a valid/ready port.
module spi_slave_rx #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sclk,
   input  logic                   mosi,
   input  logic                   cs_n,
   output logic [WORD_W-1:0]      rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic [$clog2(DEPTH):0] rx_level,
   output logic                   active,
   output logic                   frame_err,
   output logic                   overflow,
   input  logic                   clr_overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(WORD_W);
   localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
   localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

   typedef enum logic {IDLE, RECV} state_t;
   state_t state_q, state_d;

   logic              sclk_q;
   logic [CW-1:0]     bit_cnt, bit_cnt_d, cnt_after;
   logic [WORD_W-2:0] shift, shift_d;
   logic [WORD_W-1:0] word_nx;
   logic              sample, word_done, cs_fall, cs_rise, ferr_d;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              pop, push, full, ovf_set;

   // The registered select (state_q) qualifies sampling, so the last falling
   // sclk still lands when the master raises cs_n on that same clk.
   assign sample    = sclk_q && !sclk && (state_q == RECV);
   assign word_nx   = {shift, mosi};
   assign word_done = sample && (bit_cnt == LAST_BIT);
   assign cs_fall   = (state_q == IDLE) && !cs_n;
   assign cs_rise   = (state_q == RECV) && cs_n;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift;
      cnt_after = bit_cnt;
      ferr_d    = 1'b0;
      if (sample) begin
         shift_d   = word_nx[WORD_W-2:0];
         cnt_after = word_done ? '0 : bit_cnt + 1'b1;
      end
      bit_cnt_d = cnt_after;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d   = RECV;
               bit_cnt_d = '0;
            end
         end
         RECV: begin
            if (cs_rise) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               ferr_d    = (cnt_after != '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_level = wr_ptr - rd_ptr;
   assign rx_valid = (rx_level != '0);
   assign full     = (rx_level == FULL_LVL);
   assign pop      = rx_valid && rx_ready;
   assign push     = word_done && (!full || pop);
   assign ovf_set  = word_done && full && !pop;
   assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : '0;
   assign active   = (state_q == RECV);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sclk_q    <= 1'b0;
         bit_cnt   <= '0;
         shift     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sclk_q    <= sclk;
         bit_cnt   <= bit_cnt_d;
         shift     <= shift_d;
         frame_err <= ferr_d;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (ovf_set)           overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= word_nx;
   end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: table-driven frames, directed corner sequences and
// randomized frames checked every cycle against a queue-based model of the receive FIFO.
module tb_spi_slave_rx;

   localparam int unsigned W  = 32;
   localparam int unsigned D  = 4;
   localparam int unsigned LW = $clog2(D) + 1;

   logic          clk = 1'b0, rst = 1'b1;
   logic          sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1;
   logic          rx_ready = 1'b0, clr_overflow = 1'b0;
   logic [W-1:0]  rx_data;
   logic          rx_valid, active, frame_err, overflow;
   logic [LW-1:0] rx_level;

   spi_slave_rx #(.WORD_W(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_level(rx_level), .active(active), .frame_err(frame_err),
      .overflow(overflow), .clr_overflow(clr_overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_err = 0;

   // reference model: words the FIFO should hold, oldest first
   logic [W-1:0] mq[$];
   logic         m_ovf = 1'b0, m_active = 1'b0;

   int           ferr_cnt = 0, valid_cnt = 0;
   int           rdy_pct = 0, clr_pct = 0, gap_pct = 0;
   bit           rdy_on_push = 1'b0;
   logic [W-1:0] last_seen = '0;
   logic [W-1:0] fw [8];

   typedef struct {
      logic [W-1:0] word;
      int           nbits;
      bit           sim_rise;
      int           exp_level;
      int           exp_ferr;
      logic [W-1:0] exp_head;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clk cycle: drive at negedge, advance the model over the coming posedge, check at next negedge.
   task automatic step(input logic sc, input logic mo, input logic cs,
                       input bit push, input logic [W-1:0] w, input bit ferr_exp);
      logic rdy, clr;
      bit   pop, full, drop;
      rdy = rdy_on_push ? push : ($urandom_range(99) < rdy_pct);
      clr = ($urandom_range(99) < clr_pct);
      sclk = sc; mosi = mo; cs_n = cs; rx_ready = rdy; clr_overflow = clr;
      full = (mq.size() == D);
      pop  = rdy && (mq.size() != 0);
      drop = push && full && !pop;
      if (pop) void'(mq.pop_front());
      if (push && !drop) mq.push_back(w);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_active = !cs;
      @(negedge clk);
      if (frame_err) ferr_cnt++;
      if (rx_valid) begin
         valid_cnt++;
         last_seen = rx_data;
      end
      chk("frame_err", 64'(frame_err), 64'(ferr_exp));
      chk("active", 64'(active), 64'(m_active));
      chk("rx_level", 64'(rx_level), 64'(mq.size()));
      chk("rx_valid", 64'(rx_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("rx_data", 64'(rx_data), 64'(mq[0]));
      chk("overflow", 64'(overflow), 64'(m_ovf));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
   endtask

   task automatic noise(input int n);
      logic s, m;
      for (int i = 0; i < n; i++) begin
         s = 1'($urandom_range(1));
         m = 1'($urandom_range(1));
         step(s, m, 1'b1, 1'b0, '0, 1'b0);
      end
   endtask

   // Frame of nbits taken MSB-first from fw[]; a word is expected every W falling edges.
   task automatic send_frame(input int nbits, input bit sim_rise, input bit keep_cs);
      logic b;
      bit   last, done, rise, partial;
      int   g;
      partial = ((nbits % W) != 0);
      b = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < nbits; i++) begin
         g = ($urandom_range(99) < gap_pct) ? int'($urandom_range(3, 1)) : 0;
         for (int k = 0; k < g; k++) step(1'b0, b, 1'b0, 1'b0, '0, 1'b0);
         b = fw[i / W][W - 1 - (i % W)];
         step(1'b1, b, 1'b0, 1'b0, '0, 1'b0);
         last = (i == nbits - 1);
         done = (((i + 1) % W) == 0);
         rise = last && sim_rise && !keep_cs;
         step(1'b0, b, rise, done, fw[i / W], rise && partial);
      end
      if (!keep_cs && !(sim_rise && nbits > 0)) step(1'b0, 1'b0, 1'b1, 1'b0, '0, partial);
   endtask

   task automatic drain();
      int save;
      save = rdy_pct;
      rdy_pct = 100;
      for (int k = 0; k < 3 * D && mq.size() != 0; k++) idle(1);
      rdy_pct = save;
      chk("drain_empty", 64'(rx_level), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{32'hA5A5_0F0F, 32, 1'b1, 1, 0, 32'hA5A5_0F0F};
      tbl[1] = '{32'h1234_5678, 32, 1'b0, 1, 0, 32'h1234_5678};
      tbl[2] = '{32'hFFFF_FFFF, 17, 1'b1, 0, 1, 32'h0};
      tbl[3] = '{32'h0000_0001, 32, 1'b1, 1, 0, 32'h0000_0001};
      tbl[4] = '{32'h8000_0000, 31, 1'b0, 0, 1, 32'h0};
      tbl[5] = '{32'hDEAD_BEEF,  1, 1'b1, 0, 1, 32'h0};
      tbl[6] = '{32'h0F0F_0F0F,  0, 1'b0, 0, 0, 32'h0};

      // reset state
      @(negedge clk);
      chk("rst_valid", 64'(rx_valid), 64'(0));
      chk("rst_level", 64'(rx_level), 64'(0));
      chk("rst_data", 64'(rx_data), 64'(0));
      chk("rst_active", 64'(active), 64'(0));
      chk("rst_ferr", 64'(frame_err), 64'(0));
      chk("rst_ovf", 64'(overflow), 64'(0));
      rst = 1'b0;
      idle(2);

      // table-driven single frames
      for (int v = 0; v < 7; v++) begin
         fw[0] = tbl[v].word;
         rdy_pct = 0;
         ferr_cnt = 0;
         send_frame(tbl[v].nbits, tbl[v].sim_rise, 1'b0);
         idle(2);
         chk("tbl_level", 64'(rx_level), 64'(tbl[v].exp_level));
         chk("tbl_ferr_cnt", 64'(ferr_cnt), 64'(tbl[v].exp_ferr));
         if (tbl[v].exp_level != 0) chk("tbl_head", 64'(rx_data), 64'(tbl[v].exp_head));
         drain();
      end

      // T1: ready held high, word visible for exactly one cycle
      rdy_pct = 100; valid_cnt = 0; ferr_cnt = 0;
      fw[0] = 32'hA5A5_0F0F;
      send_frame(32, 1'b1, 1'b0);
      idle(3);
      chk("t1_valid_cycles", 64'(valid_cnt), 64'(1));
      chk("t1_word", 64'(last_seen), 64'(32'hA5A5_0F0F));
      chk("t1_ferr", 64'(ferr_cnt), 64'(0));

      // T2: three words in one frame, popped in order
      rdy_pct = 0;
      fw[0] = 32'h0000_0001; fw[1] = 32'h8000_0000; fw[2] = 32'hDEAD_BEEF;
      send_frame(96, 1'b1, 1'b0);
      idle(1);
      chk("t2_level", 64'(rx_level), 64'(3));
      rdy_pct = 100;
      for (int k = 0; k < 3; k++) begin
         chk("t2_order", 64'(rx_data), 64'(fw[k]));
         idle(1);
      end
      rdy_pct = 0;
      chk("t2_empty", 64'(rx_valid), 64'(0));

      // T3: truncated frame, then a clean word
      ferr_cnt = 0;
      fw[0] = 32'hFFFF_0000;
      send_frame(17, 1'b0, 1'b0);
      idle(2);
      chk("t3_ferr_pulse", 64'(ferr_cnt), 64'(1));
      chk("t3_no_push", 64'(rx_level), 64'(0));
      fw[0] = 32'h1234_5678;
      send_frame(32, 1'b1, 1'b0);
      idle(1);
      chk("t3_word", 64'(rx_data), 64'(32'h1234_5678));
      drain();

      // T4: overflow on the fifth word, then clear
      for (int k = 0; k < 5; k++) fw[k] = 32'h1111_1111 * (k + 1);
      send_frame(5 * 32, 1'b1, 1'b0);
      idle(1);
      chk("t4_level", 64'(rx_level), 64'(D));
      chk("t4_ovf", 64'(overflow), 64'(1));
      chk("t4_head", 64'(rx_data), 64'(32'h1111_1111));
      clr_pct = 100; idle(1); clr_pct = 0;
      chk("t4_ovf_clr", 64'(overflow), 64'(0));
      drain();

      // T5: full FIFO, pop in the exact completion cycle
      for (int k = 0; k < 4; k++) fw[k] = 32'hA000_0000 + k;
      send_frame(4 * 32, 1'b1, 1'b0);
      idle(1);
      fw[0] = 32'hA000_0004;
      rdy_on_push = 1'b1;
      send_frame(32, 1'b1, 1'b0);
      rdy_on_push = 1'b0;
      idle(1);
      chk("t5_level", 64'(rx_level), 64'(D));
      chk("t5_ovf", 64'(overflow), 64'(0));
      chk("t5_head", 64'(rx_data), 64'(32'hA000_0001));
      drain();

      // T6: reset mid-word with two words buffered
      fw[0] = 32'h0BAD_0001; fw[1] = 32'h0BAD_0002;
      send_frame(64, 1'b1, 1'b0);
      idle(1);
      fw[0] = 32'hFFFF_FFFF;
      send_frame(10, 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      chk("t6_valid", 64'(rx_valid), 64'(0));
      chk("t6_level", 64'(rx_level), 64'(0));
      chk("t6_data", 64'(rx_data), 64'(0));
      chk("t6_active", 64'(active), 64'(0));
      chk("t6_ferr", 64'(frame_err), 64'(0));
      chk("t6_ovf", 64'(overflow), 64'(0));
      mq.delete(); m_ovf = 1'b0; m_active = 1'b0;
      cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      fw[0] = 32'hCAFE_F00D;
      send_frame(32, 1'b1, 1'b0);
      idle(1);
      chk("t6_word", 64'(rx_data), 64'(32'hCAFE_F00D));
      drain();

      // randomized frames against the model
      for (int f = 0; f < 40; f++) begin
         rdy_pct = int'($urandom_range(100));
         gap_pct = int'($urandom_range(40));
         clr_pct = int'($urandom_range(10));
         for (int k = 0; k < 8; k++) fw[k] = $urandom;
         send_frame(int'($urandom_range(3 * W + 5)), 1'($urandom_range(1)), 1'b0);
         noise(int'($urandom_range(4)));
      end
      rdy_pct = 0; gap_pct = 0; clr_pct = 0;
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
